// File: rtl/maze_pkg.sv
// Shared maze types: direction encoding used by solver and path reader,
// reader FSM states and default geometry.
package maze_pkg;

  localparam int COORD_W_DEF = 4;
  localparam int ADDR_W_DEF  = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EMIT,
    S_FETCH,
    S_WAIT,
    S_LAST
  } rd_state_t;

endpackage

// File: rtl/maze_path_reader_if.sv
// Cell beat stream from the path reader to the display/host.
interface maze_path_reader_if #(
  parameter int COORD_W = 4
);

  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic [1:0]         dir_out;
  logic               first;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output x_out, y_out, dir_out, first, out_valid,
    input  out_ready
  );

  modport slave (
    input  x_out, y_out, dir_out, first, out_valid,
    output out_ready
  );

endinterface

// File: rtl/maze_coord_step.sv
// One maze move: next coordinates plus a flag for leaving the grid.
module maze_coord_step
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  dir_t               dir,
  output logic [COORD_W-1:0] nx,
  output logic [COORD_W-1:0] ny,
  output logic               oob
);

  localparam logic [COORD_W-1:0] MAX = '1;

  always_comb begin
    nx  = x;
    ny  = y;
    oob = 1'b0;
    unique case (dir)
      DIR_UP: begin
        ny  = y - 1'b1;
        oob = (y == '0);
      end
      DIR_RIGHT: begin
        nx  = x + 1'b1;
        oob = (x == MAX);
      end
      DIR_LEFT: begin
        nx  = x - 1'b1;
        oob = (x == '0);
      end
      DIR_DOWN: begin
        ny  = y + 1'b1;
        oob = (y == MAX);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/maze_path_reader.sv
// Replays the solver's direction stack as a stream of visited cells.
// Optional PATH_BOUNDS_CHECK_EN: stop on off-grid moves and flag path_err.
module maze_path_reader
  import maze_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W:0]   path_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  maze_path_reader_if.master beat,
  output logic              all_read,
`ifdef PATH_BOUNDS_CHECK_EN
  output logic              path_err,
`endif
  output logic              busy
);

  localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  rd_state_t          state;
  logic [COORD_W-1:0] x, y;
  logic [COORD_W-1:0] nx, ny;
  logic [ADDR_W:0]    idx, len;
  logic               step_oob;
  logic               move_ok;

  maze_coord_step #(.COORD_W(COORD_W)) u_step (
    .x   (x),
    .y   (y),
    .dir (dir_t'(rd_data)),
    .nx  (nx),
    .ny  (ny),
    .oob (step_oob)
  );

`ifdef PATH_BOUNDS_CHECK_EN
  assign move_ok = !step_oob;
`else
  logic unused_oob;
  assign unused_oob = step_oob;
  assign move_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      x              <= SX;
      y              <= SY;
      idx            <= '0;
      len            <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      beat.x_out     <= '0;
      beat.y_out     <= '0;
      beat.dir_out   <= '0;
      beat.first     <= 1'b0;
      beat.out_valid <= 1'b0;
      all_read       <= 1'b0;
      busy           <= 1'b0;
`ifdef PATH_BOUNDS_CHECK_EN
      path_err       <= 1'b0;
`endif
    end else begin
      all_read <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (run) begin
            len <= (path_len > MAX_LEN)
                 ? MAX_LEN : path_len;
            idx            <= '0;
            x              <= SX;
            y              <= SY;
            beat.x_out     <= SX;
            beat.y_out     <= SY;
            beat.dir_out   <= DIR_UP;
            beat.first     <= 1'b1;
            beat.out_valid <= 1'b1;
            busy           <= 1'b1;
`ifdef PATH_BOUNDS_CHECK_EN
            path_err       <= 1'b0;
`endif
            state          <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (beat.out_ready) begin
            beat.first     <= 1'b0;
            beat.out_valid <= 1'b0;
            if (idx == len) begin
              all_read <= 1'b1;
              state    <= S_LAST;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= idx[ADDR_W-1:0];
              state   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          rd_en <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (move_ok) begin
            x              <= nx;
            y              <= ny;
            beat.x_out     <= nx;
            beat.y_out     <= ny;
            beat.dir_out   <= rd_data;
            beat.out_valid <= 1'b1;
            idx            <= idx + 1'b1;
            state          <= S_EMIT;
          end else begin
            // off-grid move: drop it and finish without a beat
`ifdef PATH_BOUNDS_CHECK_EN
            path_err <= 1'b1;
`endif
            all_read <= 1'b1;
            state    <= S_LAST;
          end
        end
        S_LAST: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_reader.sv
// Scoreboard bench for maze_path_reader: directed paths, backpressure,
// mid-walk reset, grid-edge move and run toggled during playback.
module tb_maze_path_reader;
  import maze_pkg::*;

  localparam int CW = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [AW:0]   path_len = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data = 2'b00;
  logic          all_read;
  logic          busy;
`ifdef PATH_BOUNDS_CHECK_EN
  logic          path_err;
`endif

  maze_path_reader_if #(.COORD_W(CW)) bif ();

  maze_path_reader #(
    .COORD_W(CW), .ADDR_W(AW), .START_X(0), .START_Y(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .path_len (path_len),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .beat     (bif),
    .all_read (all_read),
`ifdef PATH_BOUNDS_CHECK_EN
    .path_err (path_err),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] d;
    logic       f;
  } beat_t;

  beat_t expq[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ar_cnt = 0;
  int exp_ar = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int last_hs = -100;
  int ar_lat = 1;
  bit gap_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input int d, input int f);
    beat_t b;
    b.x = 4'(x);
    b.y = 4'(y);
    b.d = 2'(d);
    b.f = 1'(f);
    expq.push_back(b);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: pops the scoreboard on every accepted beat
  initial begin
    beat_t got, e, prev;
    bit prev_v, prev_hs;
    prev_v = 1'b0;
    prev_hs = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_v = 1'b0;
      end else begin
        got = {bif.x_out, bif.y_out, bif.dir_out, bif.first};
        if (prev_v && !prev_hs)
          chk("hold_stable", {31'd0, bif.out_valid, got},
              {31'd0, 1'b1, prev});
        if (bif.out_valid && bif.out_ready) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL beat_extra: got %0h expected none", got);
          end else begin
            e = expq.pop_front();
            chk("beat", 32'(got), 32'(e));
            if (gap_chk && !e.f)
              chk("beat_gap", cyc - last_hs, 3);
          end
          last_hs = cyc;
          hs_cnt++;
        end
        if (all_read) begin
          ar_cnt++;
          chk("all_read_lat", cyc - last_hs, ar_lat);
        end
        if (rd_en) rd_cnt++;
        prev_v = bif.out_valid;
        prev_hs = bif.out_valid && bif.out_ready;
        prev = got;
      end
    end
  end

  task automatic start(input int len);
    path_len = 9'(len);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    chk("valid_lat", 32'(bif.out_valid), 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (ar_cnt < exp_ar && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("all_read_cnt", ar_cnt, exp_ar);
    @(posedge clk);
    #1;
    chk("idle_after", {30'd0, busy, all_read}, 0);
    chk("q_empty", expq.size(), 0);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {9'd0, bif.x_out, bif.y_out, bif.dir_out, bif.first,
               bif.out_valid, rd_en, rd_addr, all_read, busy}, 0);
  endtask

  task automatic load3();
    mem[0] = 2'b01;
    mem[1] = 2'b01;
    mem[2] = 2'b11;
  endtask

  task automatic push3();
    push(0, 0, 0, 1);
    push(1, 0, 1, 0);
    push(2, 0, 1, 0);
    push(2, 1, 3, 0);
  endtask

  initial begin
    int n, h0, r0;
    foreach (mem[i]) mem[i] = 2'b00;
    bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outs");
    rst = 1'b1;

    // 3-move path, consumer always ready
    load3();
    bif.out_ready = 1'b1;
    gap_chk = 1'b1;
    push3();
    exp_ar++;
    start(3);
    wait_done(60);

    // empty path: start cell only, no memory reads
    r0 = rd_cnt;
    push(0, 0, 0, 1);
    exp_ar++;
    start(0);
    wait_done(20);
    chk("no_rd", rd_cnt - r0, 0);

    // backpressure: 5 stalled cycles per beat
    gap_chk = 1'b0;
    bif.out_ready = 1'b0;
    push3();
    exp_ar++;
    start(3);
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!bif.out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      repeat (5) begin
        @(posedge clk);
        #1;
      end
      bif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.out_ready = 1'b0;
    end
    wait_done(20);

    // reset while waiting on the second move's read data
    bif.out_ready = 1'b1;
    gap_chk = 1'b1;
    push(0, 0, 0, 1);
    push(1, 0, 1, 0);
    start(3);
    n = 0;
    while (!(rd_en && rd_addr == 8'd1) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_fetch2", {31'd0, rd_en}, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("mid_reset_outs");
    rst = 1'b1;
    chk("mid_reset_no_ar", ar_cnt, exp_ar);
    chk("mid_reset_q", expq.size(), 0);
    push3();
    exp_ar++;
    start(3);
    wait_done(60);

    // move off the top edge from the start cell
    mem[0] = 2'b00;
    push(0, 0, 0, 1);
`ifdef PATH_BOUNDS_CHECK_EN
    ar_lat = 3;
`else
    push(0, 15, 0, 0);
`endif
    exp_ar++;
    start(1);
    wait_done(30);
    ar_lat = 1;
`ifdef PATH_BOUNDS_CHECK_EN
    chk("path_err_set", {31'd0, path_err}, 1);
`endif

    // run pulsed mid-playback must not disturb the walk
    load3();
    push3();
    exp_ar++;
    h0 = hs_cnt;
    start(3);
`ifdef PATH_BOUNDS_CHECK_EN
    chk("path_err_clr", {31'd0, path_err}, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run = 1'b0;
    wait_done(60);
    chk("beat_count", hs_cnt - h0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/maze_path_reader.md
Name: maze_path_reader

Overview:
- Read-side counterpart of the maze solver's path stack.
- Once the solver reports done, this block walks the stored direction entries from bottom (address 0) to top (address path_len-1).
- It rebuilds the rat's coordinates step by step and streams each visited cell over a valid/ready handshake to the display/host.
- It pulses all_read when the walk is finished, which returns the solver to its idle state.

Parameters:
- COORD_W, 4, width of x/y coordinates (2^COORD_W cells per axis).
- ADDR_W, 8, path memory address width; maximum path length is 2^ADDR_W entries.
- START_X, 0, x coordinate of the maze entry cell.
- START_Y, 0, y coordinate of the maze entry cell.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- run  in  1  level request to start playback; sampled only in IDLE.
- path_len  in  ADDR_W+1  number of stored moves (solver stack pointer); latched on start.
- rd_en  out  1  path memory read strobe.
- rd_addr  out  ADDR_W  path memory read address.
- rd_data  in  2  direction entry; valid the cycle after rd_en (1-cycle synchronous read).
- x_out  out  COORD_W  current cell x.
- y_out  out  COORD_W  current cell y.
- dir_out  out  2  move that produced this cell; 00 for the start cell.
- first  out  1  high with the start-cell beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- all_read  out  1  one-cycle pulse, playback complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Direction encoding (shared with the solver):
  - 00 = y-1 (up)
  - 01 = x+1 (right)
  - 10 = x-1 (left)
  - 11 = y+1 (down)
- Reset (rst==0): state=IDLE. All outputs 0. Internal x,y = START_X,START_Y; idx=0; len=0.
- Reset mid-operation aborts immediately with no all_read pulse. Any partially read path is discarded.
- FSM states:
  - IDLE: busy=0. If run==1: len<=path_len, idx<=0, x<=START_X, y<=START_Y, dir<=00, first<=1; go to EMIT.
  - EMIT: out_valid=1; x_out/y_out/dir_out/first stay stable until the handshake.
    - On out_ready==1: first<=0.
    - If idx==len, go to LAST; otherwise go to FETCH.
    - Without out_ready, stay in EMIT.
  - FETCH: rd_en=1, rd_addr=idx[ADDR_W-1:0]; go to WAIT.
  - WAIT: apply rd_data to x/y; dir<=rd_data; idx<=idx+1; go to EMIT.
  - LAST: all_read=1 for exactly one cycle; go to IDLE.
- Latency:
  - run high in IDLE → out_valid on the next cycle.
  - With out_ready tied high: one beat every 3 cycles.
  - all_read is asserted the cycle after the final handshake.
- A playback produces len+1 beats: the start cell, then one beat per move.
- path_len==0: only the start beat is produced, then all_read.
- run is ignored outside IDLE. run still high after LAST starts a new playback, so the solver must drop run before then (it leaves its read state on all_read).
- Coordinate arithmetic is unsigned, COORD_W bits, modulo 2^COORD_W (see optional feature).
- path_len above 2^ADDR_W is saturated to 2^ADDR_W on latch.
- out_valid never deasserts without a handshake, except on reset.

Optional Feature:
- Macro PATH_BOUNDS_CHECK_EN.
- Defined:
  - Adds output path_err (1 bit, reset 0).
  - In WAIT, a move that would take x or y below 0 or above 2^COORD_W-1 sets path_err=1.
  - The coordinates are not updated, no beat is emitted for that move, and the FSM goes directly to LAST (all_read pulses).
  - path_err holds until the next start from IDLE or reset.
- Undefined: no path_err port; coordinates wrap modulo 2^COORD_W.

Decomposition:
- Package maze_pkg:
  - direction typedef (DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11)
  - reader state enum
  - default COORD_W/ADDR_W constants
- The solver must import the same direction constants.
- One sub-module: maze_coord_step. Combinational; inputs x, y, dir; outputs nx, ny, oob.
- The FSM, counters and output registers stay in maze_path_reader.

Test Plan:
- Reset then run=1, path_len=3, memory = [01,01,11], out_ready=1 → beats (0,0,first=1), (1,0,01), (2,0,01), (2,1,11); beats 3 cycles apart; all_read one cycle after the 4th handshake; busy=0 next cycle.
- run=1, path_len=0 → a single beat (0,0,first=1), then all_read; rd_en never asserted.
- Same 3-move path with out_ready low for 5 cycles at each beat → every beat held stable while out_valid=1; no loss or duplication; all_read only after the 4th acceptance.
- rst driven 0 during WAIT of move 2 → next cycle all outputs 0, state IDLE, no all_read; a following run restarts from (0,0).
- Memory = [00] from the start cell (0,0): with PATH_BOUNDS_CHECK_EN → start beat only, path_err=1, all_read pulses; without the macro → second beat (0,15).
- run toggled high during an active playback → ignored; beat count is still len+1.
